// File: rtl/ads8864_ctrl.sv
`default_nettype none
// ads8864_ctrl: ADS8864 3-wire busy-indicator master (CNVST, EOC wait, SCLK read-out, 16-bit sample).
// Optional macro ADS8864_AUTO_TRIG_EN adds a periodic internal start. Rev 1.0
module ads8864_ctrl #(
`ifdef ADS8864_AUTO_TRIG_EN
  parameter logic [15:0] SAMPLE_PERIOD  = 16'd1000,
`endif
  parameter logic [7:0]  CNV_CYCLES     = 8'd4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd400,
  parameter logic [7:0]  SCLK_DIV       = 8'd2,
  parameter logic [4:0]  NUM_SCLK       = 5'd17
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic        start,
  output logic        adc_cnvst,
  output logic        adc_sclk,
  input  logic        adc_sdout,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CNV      = 3'd1,
    WAIT_EOC = 3'd2,
    READ     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state;
  logic        sdo_m, sdo_s;
  logic [15:0] cnt;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [15:0] shift;
  logic        go;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sdo_m <= 1'b1;
      sdo_s <= 1'b1;
    end else begin
      sdo_m <= adc_sdout;
      sdo_s <= sdo_m;
    end
  end

`ifdef ADS8864_AUTO_TRIG_EN
  logic [15:0] trig_cnt;
  logic        trig_tick;

  assign trig_tick = (trig_cnt == SAMPLE_PERIOD - 16'd1);

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n)       trig_cnt <= '0;
    else if (trig_tick) trig_cnt <= '0;
    else                trig_cnt <= trig_cnt + 16'd1;
  end

  // A tick arriving outside IDLE is simply not looked at by the FSM.
  assign go = start | trig_tick;
`else
  assign go = start;
`endif

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      adc_cnvst   <= 1'b0;
      adc_sclk    <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt      <= '0;
          bit_cnt  <= '0;
          adc_sclk <= 1'b0;
          if (go) begin
            adc_cnvst <= 1'b1;
            busy      <= 1'b1;
            state     <= CNV;
          end
        end
        CNV: begin
          if (cnt == {8'd0, CNV_CYCLES} - 16'd1) begin
            adc_cnvst <= 1'b0;
            cnt       <= '0;
            state     <= WAIT_EOC;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_EOC: begin
          if (!sdo_s) begin
            div_cnt <= '0;
            state   <= READ;
          end else if (cnt == TIMEOUT_CYCLES - 16'd1) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        READ: begin
          if (div_cnt == SCLK_DIV - 8'd1) begin
            div_cnt <= '0;
            if (!adc_sclk) begin
              // Sample on the rising SCLK drive; the busy-indicator bit falls off the top.
              adc_sclk <= 1'b1;
              shift    <= {shift[14:0], sdo_s};
              if (bit_cnt != NUM_SCLK) bit_cnt <= bit_cnt + 5'd1;
            end else begin
              adc_sclk <= 1'b0;
              if (bit_cnt == NUM_SCLK) state <= DONE;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        DONE: begin
          data_out   <= shift;
          data_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ads8864_ctrl.sv
`default_nettype none
// tb_ads8864_ctrl: randomized bench with a behavioural ADS8864 model (17-bit output reg from 17'hABCD, +1 per read).
module tb_ads8864_ctrl;

  logic        sysclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic        adc_cnvst, adc_sclk;
  logic        adc_sdout = 1'b1;
  logic [15:0] data_out;
  logic        data_valid, busy, timeout_err;

  ads8864_ctrl dut (
    .sysclk(sysclk), .reset_n(rst_n), .start(start),
    .adc_cnvst(adc_cnvst), .adc_sclk(adc_sclk), .adc_sdout(adc_sdout),
    .data_out(data_out), .data_valid(data_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  // ---------------- ADC behavioural model ----------------
  logic [16:0] m_val = 17'hABCD;
  int          m_idx = 0;
  int          m_wait = 0;
  bit          m_active = 1'b0;
  bit          m_cnv_d = 1'b0, m_sclk_d = 1'b0;
  bit          tie_high = 1'b0;
  int          fixed_conv = 0;
  time         eoc_time = 0;
  logic [15:0] exp_arr [0:63];
  int          n_exp = 0;

  always @(negedge sysclk) begin
    if (adc_cnvst && !m_cnv_d) begin
      adc_sdout = 1'b1;
      m_active  = 1'b0;
      m_wait    = 0;
    end
    if (!adc_cnvst && m_cnv_d && !tie_high)
      m_wait = (fixed_conv != 0) ? fixed_conv : int'($urandom_range(120, 20));
    else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        adc_sdout = m_val[16];
        m_idx     = 16;
        m_active  = 1'b1;
        eoc_time  = $time;
      end
    end
    if (m_active && adc_sclk && !m_sclk_d) begin
      if (m_idx == 0) begin
        m_active  = 1'b0;
        adc_sdout = 1'b1;
        if (n_exp < 64) exp_arr[n_exp] = m_val[15:0];
        n_exp++;
        m_val = m_val + 17'd1;
      end else begin
        m_idx--;
        adc_sdout = m_val[m_idx];
      end
    end
    m_cnv_d  = adc_cnvst;
    m_sclk_d = adc_sclk;
  end

  // ---------------- output monitor ----------------
  int          cyc = 0, cnvst_hi = 0, cnv_rises = 0, sclk_pulses = 0, overlap = 0;
  int          to_cnt = 0, to_cyc = 0, cnv_fall_cyc = 0;
  logic [15:0] got_arr [0:63];
  int          lat_arr [0:63];
  int          n_got = 0;
  bit          mon_cnv_d = 1'b0, mon_sclk_d = 1'b0;

  always @(negedge sysclk) begin
    cyc++;
    if (adc_cnvst) cnvst_hi++;
    if (adc_cnvst && !mon_cnv_d) cnv_rises++;
    if (!adc_cnvst && mon_cnv_d) cnv_fall_cyc = cyc;
    if (adc_sclk && !mon_sclk_d) sclk_pulses++;
    if (adc_cnvst && adc_sclk) overlap++;
    if (data_valid) begin
      if (n_got < 64) begin
        got_arr[n_got] = data_out;
        lat_arr[n_got] = int'(($time - eoc_time) / 10);
      end
      n_got++;
    end
    if (timeout_err) begin
      to_cnt++;
      to_cyc = cyc;
    end
    mon_cnv_d  = adc_cnvst;
    mon_sclk_d = adc_sclk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  int rd = 0;
  logic [15:0] last_exp = 16'h0000;

  task automatic pulse_start();
    @(negedge sysclk); start = 1'b1;
    @(negedge sysclk); start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      @(negedge sysclk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
    repeat (2) @(negedge sysclk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge sysclk);
    #1;
    checks++;
    if ({adc_cnvst, adc_sclk, data_valid, busy, timeout_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl: cnvst/sclk/dv/busy/to=%b required 00000",
               {adc_cnvst, adc_sclk, data_valid, busy, timeout_err});
    end
    checks++;
    if (data_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: data_out=%h required 0000", data_out);
    end
    @(negedge sysclk); rst_n = 1'b1;
    repeat (5) @(negedge sysclk);
    checks++;
    if (busy !== 1'b0 || adc_cnvst !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b cnvst=%b required 0 0", busy, adc_cnvst);
    end
  endtask

  task automatic test_single();
    int s_cnv = cnvst_hi, s_sclk = sclk_pulses, s_got = n_got, s_ov = overlap;
    pulse_start();
    wait_idle(3000);
    checks++;
    if (cnvst_hi - s_cnv != 4) begin
      errors++;
      $display("FAIL cnvst_width: got %0d cycles required 4", cnvst_hi - s_cnv);
    end
    checks++;
    if (sclk_pulses - s_sclk != 17) begin
      errors++;
      $display("FAIL sclk_count: got %0d pulses required 17", sclk_pulses - s_sclk);
    end
    checks++;
    if (n_got - s_got != 1) begin
      errors++;
      $display("FAIL single_dv: got %0d pulses required 1", n_got - s_got);
    end
    checks++;
    if (got_arr[rd] !== 16'hABCD) begin
      errors++;
      $display("FAIL first_sample: got %h required ABCD", got_arr[rd]);
    end
    checks++;
    if (lat_arr[rd] < 69 || lat_arr[rd] > 73) begin
      errors++;
      $display("FAIL eoc_latency: got %0d cycles required 71+/-2", lat_arr[rd]);
    end
    checks++;
    if (overlap != s_ov) begin
      errors++;
      $display("FAIL cnvst_sclk_overlap: got %0d cycles required 0", overlap - s_ov);
    end
    last_exp = 16'hABCD;
    rd++;
  endtask

  task automatic test_back_to_back();
    int s_got = n_got;
    for (int k = 0; k < 2; k++) begin
      pulse_start();
      wait_idle(3000);
    end
    checks++;
    if (n_got - s_got != 2) begin
      errors++;
      $display("FAIL b2b_dv: got %0d pulses required 2", n_got - s_got);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got_arr[rd] !== exp_arr[rd] || exp_arr[rd] !== last_exp + 16'd1) begin
        errors++;
        $display("FAIL b2b_sample%0d: got %h required %h", k, got_arr[rd], last_exp + 16'd1);
      end
      last_exp = last_exp + 16'd1;
      rd++;
    end
    checks++;
    if (lat_arr[rd-1] != lat_arr[rd-2]) begin
      errors++;
      $display("FAIL b2b_latency: got %0d required %0d", lat_arr[rd-1], lat_arr[rd-2]);
    end
  endtask

  task automatic test_timeout();
    int s_got = n_got, s_to = to_cnt, n = 0;
    tie_high = 1'b1;
    pulse_start();
    while (!timeout_err && n < 1000) begin
      @(negedge sysclk);
      n++;
    end
    repeat (2) @(negedge sysclk);
    checks++;
    if (to_cnt - s_to != 1) begin
      errors++;
      $display("FAIL timeout_pulse: got %0d pulses required 1", to_cnt - s_to);
    end
    checks++;
    if (to_cyc - cnv_fall_cyc < 398 || to_cyc - cnv_fall_cyc > 402) begin
      errors++;
      $display("FAIL timeout_time: got %0d cycles required 400+/-2", to_cyc - cnv_fall_cyc);
    end
    checks++;
    if (n_got != s_got || busy !== 1'b0 || data_out !== last_exp) begin
      errors++;
      $display("FAIL timeout_state: dv=%0d busy=%b data=%h required 0 0 %h",
               n_got - s_got, busy, data_out, last_exp);
    end
    tie_high = 1'b0;
  endtask

  task automatic test_start_held();
    int s_got = n_got, s_rise = cnv_rises, s_hi = cnvst_hi, seen = 0, n = 0;
    @(negedge sysclk); start = 1'b1;
    while (seen < 3 && n < 3000) begin
      @(negedge sysclk);
      n++;
      if (data_valid) seen++;
    end
    start = 1'b0;
    wait_idle(3000);
    checks++;
    if (cnv_rises - s_rise != 3 || cnvst_hi - s_hi != 12) begin
      errors++;
      $display("FAIL held_conversions: got %0d starts/%0d hi required 3/12",
               cnv_rises - s_rise, cnvst_hi - s_hi);
    end
    checks++;
    if (n_got - s_got != 3) begin
      errors++;
      $display("FAIL held_dv: got %0d pulses required 3", n_got - s_got);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_arr[rd] !== exp_arr[rd] || exp_arr[rd] !== last_exp + 16'd1) begin
        errors++;
        $display("FAIL held_sample%0d: got %h required %h", k, got_arr[rd], last_exp + 16'd1);
      end
      last_exp = last_exp + 16'd1;
      rd++;
    end
  endtask

  task automatic test_reset_during_read();
    int s_sclk = sclk_pulses, n = 0, s_got;
    pulse_start();
    while (sclk_pulses - s_sclk < 5 && n < 1000) begin
      @(negedge sysclk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({adc_sclk, adc_cnvst, busy} !== 3'b000 || data_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_in_read: sclk/cnvst/busy=%b data=%h required 000 0000",
               {adc_sclk, adc_cnvst, busy}, data_out);
    end
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (3) @(negedge sysclk);
    s_got = n_got;
    pulse_start();
    wait_idle(3000);
    checks++;
    if (n_got - s_got != 1 || got_arr[rd] !== exp_arr[rd] || exp_arr[rd] !== last_exp + 16'd1) begin
      errors++;
      $display("FAIL after_reset_sample: dv=%0d got %h required 1 %h",
               n_got - s_got, got_arr[rd], last_exp + 16'd1);
    end
    last_exp = last_exp + 16'd1;
    rd++;
  endtask

`ifdef ADS8864_AUTO_TRIG_EN
  task automatic test_auto_trigger();
    int t_dv [0:3];
    int seen = 0, n = 0;
    fixed_conv = 50;
    while (seen < 4 && n < 6000) begin
      @(negedge sysclk);
      n++;
      if (data_valid) begin
        t_dv[seen] = n;
        seen++;
      end
    end
    repeat (2) @(negedge sysclk);
    checks++;
    if (seen != 4) begin
      errors++;
      $display("FAIL auto_count: got %0d samples required 4", seen);
    end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (seen == 4 && t_dv[k] - t_dv[k-1] != 1000) begin
        errors++;
        $display("FAIL auto_period%0d: got %0d cycles required 1000", k, t_dv[k] - t_dv[k-1]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_arr[k] !== 16'hABCD + 16'(k) || got_arr[k] !== exp_arr[k]) begin
        errors++;
        $display("FAIL auto_sample%0d: got %h required %h", k, got_arr[k], 16'hABCD + 16'(k));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef ADS8864_AUTO_TRIG_EN
    test_auto_trigger();
`else
    test_single();
    test_back_to_back();
    test_timeout();
    test_start_held();
    test_reset_during_read();
    checks++;
    if (n_got != n_exp) begin
      errors++;
      $display("FAIL sample_total: got %0d samples required %0d", n_got, n_exp);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
